imm_gen_pipe: RTL and testbench

Registered, handshaked immediate generator for the decode stage. Takes a full 32-bit instruction word plus an immediate-type select. Produces the sign- or zero-extended immediate at a parametrised datapath width, carrying a sideband tag (PC index / ROB slot) alongside it. A 2-entry skid buffer lets ID/EX backpressure stall the stage without dropping or duplicating instructions; a flush input kills everything in flight.

---
 rtl/imm_pkg.sv | 32 +++
 rtl/imm_decode.sv | 49 ++++
 rtl/imm_gen_pipe.sv | 143 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: shared types and constants for the immediate-generator slice.
//   imm_sel_e  - 3-bit immediate-type select (110/111 reserved, always illegal;
//                101 is the CSR zimm type, legal only when IMM_CSR_Z_EN is defined)
//   occ_e      - occupancy of the output/skid slot pair
//   xlen_legal - datapath-width legality check used at elaboration
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_RSV6 = 3'b110,
    IMM_RSV7 = 3'b111
  } imm_sel_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int unsigned XLEN_NARROW = 32;
  localparam int unsigned XLEN_WIDE   = 64;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == XLEN_NARROW) || (xlen == XLEN_WIDE);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction and extension.
//   instr   [31:0]     raw instruction word
//   imm_sel [2:0]      immediate type (imm_sel_e)
//   imm     [XLEN-1:0] extended immediate, zero for an illegal select
//   illegal            imm_sel is not a supported encoding
// Configuration: IMM_CSR_Z_EN enables the Z (CSR uimm) type on select 101.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;
  // Opcode field never contributes to any immediate.
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (imm_sel_e'(imm_sel))
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
`ifdef IMM_CSR_Z_EN
      IMM_Z: imm32 = {27'b0, instr[19:15]};
`endif
      default: begin
        imm32   = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // Every signed type already carries instr[31] in bit 31 and Z has bit 31
  // clear, so one signed widening covers both sign and zero extension.
  assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, handshaked immediate generator with a 2-entry
// skid buffer (slot 0 = output register, slot 1 = skid register).
//   clk, rst                    clock, asynchronous active-high reset
//   flush                       synchronous kill of every held entry
//   in_valid / in_ready         upstream handshake (in_ready is registered)
//   instr, imm_sel, in_tag      instruction word, immediate type, sideband tag
//   out_valid / out_ready       downstream handshake
//   imm_ext, out_tag, illegal   slot-0 immediate, its tag, illegal-select flag
// Configuration: IMM_CSR_Z_EN (see imm_decode) enables select 101.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  localparam bit XLEN_OK = xlen_legal(XLEN);

  generate
    if (!XLEN_OK) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;

  occ_e             state;
  occ_e             state_next;
  logic             in_ready_q;

  logic [XLEN-1:0]  s0_imm;
  logic [TAG_W-1:0] s0_tag;
  logic             s0_ill;
  logic [XLEN-1:0]  s1_imm;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_ill;

  logic             in_xfer;
  logic             out_xfer;
  logic             load_s0_in;
  logic             load_s0_skid;
  logic             load_s1;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr   (instr),
    .imm_sel (imm_sel),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = (state != OCC_EMPTY) && out_ready;

  always_comb begin
    state_next   = state;
    load_s0_in   = 1'b0;
    load_s0_skid = 1'b0;
    load_s1      = 1'b0;
    if (flush) begin
      state_next = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (in_xfer) begin
            load_s0_in = 1'b1;
            state_next = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_xfer && out_xfer) begin
            load_s0_in = 1'b1;
          end else if (in_xfer) begin
            load_s1    = 1'b1;
            state_next = OCC_FULL;
          end else if (out_xfer) begin
            state_next = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (out_xfer) begin
            load_s0_skid = 1'b1;
            state_next   = OCC_ONE;
          end
        end
        default: state_next = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      s0_imm     <= '0;
      s0_tag     <= '0;
      s0_ill     <= 1'b0;
      s1_imm     <= '0;
      s1_tag     <= '0;
      s1_ill     <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != OCC_FULL);
      if (load_s0_in) begin
        s0_imm <= dec_imm;
        s0_tag <= in_tag;
        s0_ill <= dec_illegal;
      end else if (load_s0_skid) begin
        s0_imm <= s1_imm;
        s0_tag <= s1_tag;
        s0_ill <= s1_ill;
      end
      if (load_s1) begin
        s1_imm <= dec_imm;
        s1_tag <= in_tag;
        s1_ill <= dec_illegal;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != OCC_EMPTY);
  assign imm_ext   = s0_imm;
  assign out_tag   = s0_tag;
  assign illegal   = s0_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe, XLEN=32 and XLEN=64
// instances sharing one input stream. Build with or without IMM_CSR_Z_EN.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] imm32;
  logic [7:0]  tag32;
  logic        ill32;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] imm64;
  logic [7:0]  tag64;
  logic        ill64;

  int unsigned n_checks;
  int unsigned n_errors;

  imm_gen_pipe #(
    .XLEN  (32),
    .TAG_W (8)
  ) dut32 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .instr     (instr),
    .imm_sel   (imm_sel),
    .in_tag    (in_tag),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .imm_ext   (imm32),
    .out_tag   (tag32),
    .illegal   (ill32)
  );

  imm_gen_pipe #(
    .XLEN  (64),
    .TAG_W (8)
  ) dut64 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready64),
    .instr     (instr),
    .imm_sel   (imm_sel),
    .in_tag    (in_tag),
    .out_valid (out_valid64),
    .out_ready (out_ready),
    .imm_ext   (imm64),
    .out_tag   (tag64),
    .illegal   (ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One entry in, sampled one cycle later on both widths; out_ready stays high
  // so it drains while the next vector loads.
  task automatic send_one(input string name, input logic [31:0] ins, input logic [2:0] sel,
                          input logic [7:0] tag, input logic [31:0] e32,
                          input logic [63:0] e64, input logic eill);
    @(negedge clk);
    in_valid  = 1'b1;
    instr     = ins;
    imm_sel   = sel;
    in_tag    = tag;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({name, "_valid"}, 64'(out_valid32), 64'd1);
    check({name, "_imm32"}, 64'(imm32), 64'(e32));
    check({name, "_ill32"}, 64'(ill32), 64'(eill));
    check({name, "_tag32"}, 64'(tag32), 64'(tag));
    check({name, "_imm64"}, imm64, e64);
    check({name, "_ill64"}, 64'(ill64), 64'(eill));
  endtask

  logic [31:0] z_exp32;
  logic        z_expill;
  logic [7:0]  q[$];
  int unsigned next_tag;
  int unsigned got_count;
  logic        saw_stall;
  logic        in_fire;
  logic        out_fire;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    imm_sel   = '0;
    in_tag    = '0;
    out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_out_valid", 64'(out_valid32), 64'd0);
    check("rst_in_ready", 64'(in_ready32), 64'd1);
    check("rst_imm", 64'(imm32), 64'd0);
    check("rst_tag", 64'(tag32), 64'd0);
    check("rst_illegal", 64'(ill32), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed decode vectors
    send_one("i_neg1", 32'hFFF00093, 3'b000, 8'h11, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send_one("s_neg4", 32'hFE112E23, 3'b001, 8'h12, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send_one("b_neg4", 32'hFE000EE3, 3'b010, 8'h13, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send_one("b_pos8", 32'h00000463, 3'b010, 8'h14, 32'h00000008, 64'h0000000000000008, 1'b0);
    send_one("j_pos8", 32'h0080006F, 3'b011, 8'h15, 32'h00000008, 64'h0000000000000008, 1'b0);
    send_one("u_pos", 32'h123450B7, 3'b100, 8'h16, 32'h12345000, 64'h0000000012345000, 1'b0);
    send_one("u_neg", 32'h800000B7, 3'b100, 8'h17, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
`ifdef IMM_CSR_Z_EN
    z_exp32  = 32'h0000001F;
    z_expill = 1'b0;
`else
    z_exp32  = 32'h00000000;
    z_expill = 1'b1;
`endif
    send_one("z_1f", 32'h000F8073, 3'b101, 8'h18, z_exp32, 64'(z_exp32), z_expill);
    send_one("sel110", 32'hFFFFFFFF, 3'b110, 8'h19, 32'h0, 64'h0, 1'b1);
    send_one("sel111", 32'hFFFFFFFF, 3'b111, 8'h1A, 32'h0, 64'h0, 1'b1);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_empty", 64'(out_valid32), 64'd0);

    // Backpressure: tags 1..6 offered continuously, out_ready low in cycles 2-4
    next_tag  = 1;
    got_count = 0;
    saw_stall = 1'b0;
    q.delete();
    for (int unsigned cyc = 0; cyc < 40 && got_count < 6; cyc++) begin
      @(negedge clk);
      in_valid  = (next_tag <= 6);
      in_tag    = 8'(next_tag);
      instr     = 32'hFFF00093;
      imm_sel   = 3'b000;
      out_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      check("bp_in_ready", 64'(in_ready32), 64'(q.size() != 2));
      check("bp_out_valid", 64'(out_valid32), 64'(q.size() != 0));
      if (q.size() != 0) check("bp_tag", 64'(tag32), 64'(q[0]));
      if (!in_ready32) saw_stall = 1'b1;
      in_fire  = in_valid && in_ready32;
      out_fire = out_valid32 && out_ready;
      @(posedge clk);
      if (out_fire) begin
        void'(q.pop_front());
        got_count++;
      end
      if (in_fire) begin
        q.push_back(8'(next_tag));
        next_tag++;
      end
    end
    check("bp_tag_count", 64'(got_count), 64'd6);
    check("bp_stalled", 64'(saw_stall), 64'd1);

    // Flush while FULL with in_valid high
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_tag    = 8'hA1;
    @(negedge clk);
    in_tag = 8'hA2;
    @(posedge clk);
    #1;
    check("fl_full_in_ready", 64'(in_ready32), 64'd0);
    @(negedge clk);
    in_tag = 8'hA3;
    flush  = 1'b1;
    @(posedge clk);
    #1;
    check("fl_out_valid", 64'(out_valid32), 64'd0);
    check("fl_in_ready", 64'(in_ready32), 64'd1);
    @(negedge clk);
    flush     = 1'b0;
    in_tag    = 8'hA4;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("fl_next_valid", 64'(out_valid32), 64'd1);
    check("fl_next_tag", 64'(tag32), 64'hA4);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("fl_drained", 64'(out_valid32), 64'd0);

    // Flush in ONE with an accepted-looking input in the same cycle
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_tag    = 8'hB1;
    @(negedge clk);
    in_tag = 8'hB2;
    flush  = 1'b1;
    @(posedge clk);
    #1;
    check("fl1_out_valid", 64'(out_valid32), 64'd0);
    check("fl1_in_ready", 64'(in_ready32), 64'd1);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset while holding an entry
    @(negedge clk);
    in_valid = 1'b1;
    in_tag   = 8'hC1;
    @(posedge clk);
    #1;
    check("ar_loaded", 64'(out_valid32), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 64'(out_valid32), 64'd0);
    check("ar_tag", 64'(tag32), 64'd0);
    check("ar_imm", 64'(imm32), 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ar_in_ready", 64'(in_ready32), 64'd1);
    check("ar_stays_empty", 64'(out_valid32), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
